// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared types and constants for the load/store unit
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } lsu_state_e;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

endpackage

// File: rtl/lsu_lane.sv
// rtl/lsu_lane.sv - byte-lane select, store replication, load extraction and access checks
module lsu_lane
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic        is_store,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [3:0]  sel,
    output logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic        misaligned,
    output logic        illegal
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    // Pick the addressed byte and halfword out of the returned word.
    always_comb begin
        byte_v = rdata[{addr_lo, 3'b000} +: 8];
        half_v = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    end

    // Decode size/sign: enables, replicated store data, extended load data, faults.
    always_comb begin
        sel        = 4'b0000;
        wdata      = store_data;
        load_data  = 32'h0;
        misaligned = 1'b0;
        illegal    = 1'b0;
        case (funct3)
            F3_B, F3_BU: begin
                sel       = 4'b0001 << addr_lo;
                wdata     = {4{store_data[7:0]}};
                load_data = (funct3 == F3_B) ? {{24{byte_v[7]}}, byte_v} : {24'h0, byte_v};
                illegal   = is_store && (funct3 == F3_BU);
            end
            F3_H, F3_HU: begin
                sel        = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata      = {2{store_data[15:0]}};
                load_data  = (funct3 == F3_H) ? {{16{half_v[15]}}, half_v} : {16'h0, half_v};
                misaligned = addr_lo[0];
                illegal    = is_store && (funct3 == F3_HU);
            end
            F3_W: begin
                sel        = 4'b1111;
                wdata      = store_data;
                load_data  = rdata;
                misaligned = (addr_lo != 2'b00);
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - one bus transaction per load/store with pipeline stall and writeback
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic [4:0]  rd_in,
    input  logic [31:0] read_address,
    input  logic [31:0] write_address,
    input  logic [31:0] result,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack,
    output logic        bus_read,
    output logic        bus_write,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_sel,
    output logic [31:0] reg_write,
    output logic [4:0]  rd,
    output logic        writeEnable,
    output logic        stall,
    output logic        err
);

    localparam int CW = $clog2(TIMEOUT + 1);

    lsu_state_e  state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]  funct3_q, funct3_d;
    logic        is_store_q, is_store_d;
    logic [1:0]  addr_lo_q, addr_lo_d;
    logic        bus_read_q, bus_read_d;
    logic        bus_write_q, bus_write_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic [3:0]  bus_sel_q, bus_sel_d;
    logic [31:0] reg_write_q, reg_write_d;
    logic [4:0]  rd_q, rd_d;
    logic        we_q, we_d;
    logic        err_q, err_d;

    logic        op_store;
    logic        mem_op;
    logic        in_idle;
    logic [31:0] acc_addr;
    logic [2:0]  lane_f3;
    logic        lane_store;
    logic [1:0]  lane_addr;
    logic [3:0]  lane_sel;
    logic [31:0] lane_wdata;
    logic [31:0] lane_load;
    logic        lane_misaligned;
    logic        lane_illegal;

    // The lane decoder sees the incoming instruction while idle and the held one afterwards.
    always_comb begin
        op_store   = (opcode == OP_STORE);
        mem_op     = ex_valid && ((opcode == OP_LOAD) || op_store);
        in_idle    = (state_q == IDLE);
        acc_addr   = op_store ? write_address : read_address;
        lane_f3    = in_idle ? funct3 : funct3_q;
        lane_store = in_idle ? op_store : is_store_q;
        lane_addr  = in_idle ? acc_addr[1:0] : addr_lo_q;
    end

    lsu_lane u_lane (
        .funct3     (lane_f3),
        .is_store   (lane_store),
        .addr_lo    (lane_addr),
        .store_data (result),
        .rdata      (bus_rdata),
        .sel        (lane_sel),
        .wdata      (lane_wdata),
        .load_data  (lane_load),
        .misaligned (lane_misaligned),
        .illegal    (lane_illegal)
    );

    // Next-state and next-output logic for the IDLE/REQ/DONE transaction sequencer.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        funct3_d    = funct3_q;
        is_store_d  = is_store_q;
        addr_lo_d   = addr_lo_q;
        bus_read_d  = bus_read_q;
        bus_write_d = bus_write_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        bus_sel_d   = bus_sel_q;
        reg_write_d = reg_write_q;
        rd_d        = rd_q;
        we_d        = 1'b0;
        err_d       = 1'b0;
        case (state_q)
            IDLE: begin
                if (mem_op) begin
                    funct3_d    = funct3;
                    is_store_d  = op_store;
                    addr_lo_d   = acc_addr[1:0];
                    rd_d        = rd_in;
                    cnt_d       = '0;
                    bus_addr_d  = {acc_addr[31:2], 2'b00};
                    bus_sel_d   = lane_sel;
                    bus_wdata_d = lane_wdata;
                    if (lane_misaligned || lane_illegal) begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        bus_read_d  = !op_store;
                        bus_write_d = op_store;
                        state_d     = REQ;
                    end
                end
            end
            REQ: begin
                cnt_d = cnt_q + CW'(1);
                if (bus_ack) begin
                    bus_read_d  = 1'b0;
                    bus_write_d = 1'b0;
                    if (!is_store_q) begin
                        reg_write_d = lane_load;
                        we_d        = (rd_q != 5'd0);
                    end
                    state_d = DONE;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    // Last permitted REQ cycle passed without an ack: abandon the access.
                    bus_read_d  = 1'b0;
                    bus_write_d = 1'b0;
                    err_d       = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs; reset clears the bus strobes immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            funct3_q    <= 3'b000;
            is_store_q  <= 1'b0;
            addr_lo_q   <= 2'b00;
            bus_read_q  <= 1'b0;
            bus_write_q <= 1'b0;
            bus_addr_q  <= 32'h0;
            bus_wdata_q <= 32'h0;
            bus_sel_q   <= 4'h0;
            reg_write_q <= 32'h0;
            rd_q        <= 5'd0;
            we_q        <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            funct3_q    <= funct3_d;
            is_store_q  <= is_store_d;
            addr_lo_q   <= addr_lo_d;
            bus_read_q  <= bus_read_d;
            bus_write_q <= bus_write_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            bus_sel_q   <= bus_sel_d;
            reg_write_q <= reg_write_d;
            rd_q        <= rd_d;
            we_q        <= we_d;
            err_q       <= err_d;
        end
    end

    assign bus_read    = bus_read_q;
    assign bus_write   = bus_write_q;
    assign bus_addr    = bus_addr_q;
    assign bus_wdata   = bus_wdata_q;
    assign bus_sel     = bus_sel_q;
    assign reg_write   = reg_write_q;
    assign rd          = rd_q;
    assign writeEnable = we_q;
    assign err         = err_q;
    assign stall       = (in_idle && mem_op) || (state_q == REQ);

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed self-checking bench for load_store_unit
module tb_load_store_unit;

    localparam logic [6:0] OPL = 7'b0000011;
    localparam logic [6:0] OPS = 7'b0100011;
    localparam logic [6:0] OPR = 7'b0110011;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ex_valid = 1'b0;
    logic [6:0]  opcode = 7'h0;
    logic [2:0]  funct3 = 3'h0;
    logic [4:0]  rd_in = 5'h0;
    logic [31:0] read_address = 32'h0;
    logic [31:0] write_address = 32'h0;
    logic [31:0] result = 32'h0;
    logic [31:0] bus_rdata = 32'h0;
    logic        bus_ack = 1'b0;
    logic        bus_read, bus_write, writeEnable, stall, err;
    logic [31:0] bus_addr, bus_wdata, reg_write;
    logic [3:0]  bus_sel;
    logic [4:0]  rd;

    int vectors = 0;
    int miscompares = 0;
    int n;

    load_store_unit #(.TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .opcode(opcode), .funct3(funct3),
        .rd_in(rd_in), .read_address(read_address), .write_address(write_address),
        .result(result), .bus_rdata(bus_rdata), .bus_ack(bus_ack),
        .bus_read(bus_read), .bus_write(bus_write), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_sel(bus_sel), .reg_write(reg_write), .rd(rd),
        .writeEnable(writeEnable), .stall(stall), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present an instruction; the unused address port gets the complement to catch a wrong mux.
    task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] d, input logic [4:0] r);
        ex_valid      = 1'b1;
        opcode        = op;
        funct3        = f3;
        read_address  = (op == OPS) ? ~a : a;
        write_address = (op == OPS) ? a : ~a;
        result        = d;
        rd_in         = r;
    endtask

    initial begin
        // Reset state
        tick();
        chk("rst_bus_read", bus_read, 0);
        chk("rst_stall", stall, 0);
        chk("rst_outputs", {bus_addr ^ bus_wdata ^ reg_write, bus_sel, rd, writeEnable, err, bus_write}, 0);
        rst = 1'b1;
        tick();

        // LW 0x100 rd=5, ack in first REQ cycle
        issue(OPL, 3'b010, 32'h100, 32'h0, 5'd5);
        #1 chk("lw_stall_T", stall, 1);
        tick();
        ex_valid = 1'b0; bus_ack = 1'b1; bus_rdata = 32'hDEADBEEF;
        chk("lw_bus_read", bus_read, 1);
        chk("lw_bus_addr", bus_addr, 32'h100);
        chk("lw_bus_sel", bus_sel, 4'hF);
        chk("lw_stall_T1", stall, 1);
        tick();
        bus_ack = 1'b0;
        chk("lw_we", writeEnable, 1);
        chk("lw_rd", rd, 5);
        chk("lw_data", reg_write, 32'hDEADBEEF);
        chk("lw_stall_T2", stall, 0);
        chk("lw_strobe_drop", bus_read, 0);
        tick();
        chk("lw_we_pulse", writeEnable, 0);

        // LB / LBU at 0x103
        issue(OPL, 3'b000, 32'h103, 32'h0, 5'd7);
        tick();
        ex_valid = 1'b0; bus_ack = 1'b1; bus_rdata = 32'h80FFFFFF;
        chk("lb_sel", bus_sel, 4'b1000);
        tick();
        bus_ack = 1'b0;
        chk("lb_data", reg_write, 32'hFFFFFF80);
        tick();
        issue(OPL, 3'b100, 32'h103, 32'h0, 5'd7);
        tick();
        ex_valid = 1'b0; bus_ack = 1'b1;
        tick();
        bus_ack = 1'b0;
        chk("lbu_data", reg_write, 32'h00000080);
        chk("lbu_we", writeEnable, 1);
        tick();

        // LH at 0x102, sign from upper half
        issue(OPL, 3'b001, 32'h102, 32'h0, 5'd9);
        tick();
        ex_valid = 1'b0; bus_ack = 1'b1; bus_rdata = 32'h9ABC1234;
        tick();
        bus_ack = 1'b0;
        chk("lh_data", reg_write, 32'hFFFF9ABC);
        tick();

        // SH 0x202, ack on the third REQ cycle
        issue(OPS, 3'b001, 32'h202, 32'h1234ABCD, 5'd0);
        tick();
        ex_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("sh_bus_write", bus_write, 1);
            chk("sh_addr", bus_addr, 32'h200);
            chk("sh_sel", bus_sel, 4'b1100);
            chk("sh_wdata", bus_wdata, 32'hABCDABCD);
            if (i == 2) bus_ack = 1'b1;
            tick();
        end
        bus_ack = 1'b0;
        chk("sh_no_we", writeEnable, 0);
        chk("sh_write_drop", bus_write, 0);
        chk("sh_no_err", err, 0);
        tick();

        // SB 0x201 lane replication
        issue(OPS, 3'b000, 32'h201, 32'h000000A5, 5'd0);
        tick();
        ex_valid = 1'b0; bus_ack = 1'b1;
        chk("sb_sel", bus_sel, 4'b0010);
        chk("sb_wdata", bus_wdata, 32'hA5A5A5A5);
        tick();
        bus_ack = 1'b0;
        tick();

        // Misaligned LW 0x101
        issue(OPL, 3'b010, 32'h101, 32'h0, 5'd6);
        #1 chk("mis_stall_T", stall, 1);
        tick();
        ex_valid = 1'b0;
        chk("mis_err", err, 1);
        chk("mis_no_strobe", bus_read, 0);
        chk("mis_no_we", writeEnable, 0);
        chk("mis_stall_done", stall, 0);
        tick();
        chk("mis_err_pulse", err, 0);

        // Illegal store funct3
        issue(OPS, 3'b100, 32'h300, 32'h0, 5'd0);
        tick();
        ex_valid = 1'b0;
        chk("ill_err", err, 1);
        chk("ill_no_strobe", bus_write, 0);
        tick();

        // Non-memory opcode
        issue(OPR, 3'b000, 32'h100, 32'h0, 5'd3);
        #1 chk("alu_stall", stall, 0);
        tick();
        ex_valid = 1'b0;
        chk("alu_no_strobe", {bus_read, bus_write, err}, 0);

        // Timeout: no ack at all
        issue(OPL, 3'b010, 32'h400, 32'h0, 5'd3);
        tick();
        ex_valid = 1'b0;
        n = 0;
        while (bus_read && n < 40) begin
            n++;
            tick();
        end
        chk("to_strobe_cycles", n, 16);
        chk("to_err", err, 1);
        chk("to_no_we", writeEnable, 0);
        tick();

        // Ack on the sixteenth REQ cycle wins over timeout
        issue(OPL, 3'b010, 32'h404, 32'h0, 5'd4);
        tick();
        ex_valid = 1'b0; bus_rdata = 32'h00C0FFEE;
        repeat (15) tick();
        chk("late_still_req", bus_read, 1);
        bus_ack = 1'b1;
        tick();
        bus_ack = 1'b0;
        chk("late_we", writeEnable, 1);
        chk("late_no_err", err, 0);
        chk("late_data", reg_write, 32'h00C0FFEE);
        tick();

        // LW with rd=0 writes nothing
        issue(OPL, 3'b010, 32'h108, 32'h0, 5'd0);
        tick();
        ex_valid = 1'b0; bus_ack = 1'b1;
        tick();
        bus_ack = 1'b0;
        chk("rd0_no_we", writeEnable, 0);
        chk("rd0_no_err", err, 0);
        tick();

        // Reset in the middle of REQ
        issue(OPL, 3'b010, 32'h500, 32'h0, 5'd8);
        tick();
        ex_valid = 1'b0;
        chk("mid_req_strobe", bus_read, 1);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_strobe", bus_read, 0);
        chk("mid_rst_outputs", {bus_addr ^ reg_write, bus_sel, rd, writeEnable, err, stall}, 0);
        bus_ack = 1'b1;
        tick();
        chk("mid_rst_no_we", writeEnable, 0);
        bus_ack = 1'b0;
        rst = 1'b1;
        tick();
        issue(OPL, 3'b010, 32'h600, 32'h0, 5'd11);
        tick();
        ex_valid = 1'b0; bus_ack = 1'b1; bus_rdata = 32'h13579BDF;
        chk("post_rst_addr", bus_addr, 32'h600);
        tick();
        bus_ack = 1'b0;
        chk("post_rst_we", writeEnable, 1);
        chk("post_rst_data", reg_write, 32'h13579BDF);
        chk("post_rst_rd", rd, 11);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Writeback and fault must never coincide.
    always @(negedge clk) begin
        assert (!(writeEnable && err)) else begin
            miscompares++;
            $error("FAIL we_err_exclusive observed=%b%b expected=not both", writeEnable, err);
        end
    end

endmodule
